dbg_mailbox_tx: RTL and testbench



---
 rtl/dbg_mailbox_pkg.sv | 28 ++
 rtl/dbg_mailbox_tx_uart.sv | 104 ++++++++++
 rtl/dbg_mailbox_tx.sv | 165 ++++++++++++++++
 tb/tb_dbg_mailbox_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_mailbox_pkg.sv
// Shared constants for the debug mailbox: function codes, status bit
// positions, transmitter states and the hex-digit helper.
package dbg_mailbox_pkg;

  localparam logic [31:0] DBG_EXIT       = 32'h0000_0000;
  localparam logic [31:0] DBG_ASSERT_EQ  = 32'h0000_0001;
  localparam logic [31:0] DBG_ASSERT_NE  = 32'h0000_0002;
  localparam logic [31:0] DBG_PRINT      = 32'h0000_0003;
  localparam logic [31:0] DBG_PRINT_HEX  = 32'h0000_0004;
  localparam logic [31:0] DBG_CHECK_REGS = 32'h0001_0000;
  localparam logic [31:0] DBG_DUMP       = 32'hffff_0000;

  localparam int ST_BUSY        = 0;
  localparam int ST_HALTED      = 1;
  localparam int ST_ASSERT_FAIL = 2;
  localparam int ST_OVERFLOW    = 3;
  localparam int ST_UNSUPPORTED = 4;
  localparam int ST_FAIL_LSB    = 8;
  localparam int ST_LEVEL_LSB   = 16;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Uppercase ASCII for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/dbg_mailbox_tx_uart.sv
// 8N1 serial transmitter. One byte is accepted on valid && ready; ready is
// high in IDLE and in the last STOP cycle so frames can run back-to-back.
module uart_tx_8n1
  import dbg_mailbox_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       idle,
  output logic       tx
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          last_tick;

  assign last_tick = (cnt_q == CW'(CLK_DIV - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: bit timing and frame sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      TX_IDLE: begin
        if (valid) begin
          shift_d = data;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (last_tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (last_tick) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (last_tick) begin
          cnt_d = '0;
          if (valid) begin
            shift_d = data;
            bit_d   = '0;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs: line level and handshake derived from the state.
  always_comb begin
    ready = (state_q == TX_IDLE) || ((state_q == TX_STOP) && last_tick);
    idle  = (state_q == TX_IDLE);
    case (state_q)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = shift_q[0];
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/dbg_mailbox_tx.sv
// Debug-RAM mailbox: argument words, one-cycle command execution, sticky
// status and a character FIFO feeding an 8N1 transmitter.
// Build option DBG_MAILBOX_HEX_EN enables function 4 (print arg1 as hex).
module dbg_mailbox_tx
  import dbg_mailbox_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic        halted,
  output logic        assert_fail
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [7:0][31:0]            args_q, args_d;
  logic                        trigger_q, trigger_d;
  logic                        halted_q, halted_d;
  logic                        assert_fail_q, assert_fail_d;
  logic                        overflow_q, overflow_d;
  logic                        unsupported_q, unsupported_d;
  logic [7:0]                  fail_cnt_q, fail_cnt_d;
  logic [FIFO_DEPTH-1:0][7:0]  mem_q, mem_d;
  logic [PW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]               level_q, level_d, free;

  logic                        exec, set_halt, do_fail, set_unsup, want_print;
  logic [3:0]                  req_n, push_n;
  logic [7:0][7:0]             bytes;
  logic                        fits, pop, tx_ready, tx_idle;
  logic [31:0]                 status;

  assign exec = trigger_q && !halted_q;
  assign free = LW'(FIFO_DEPTH) - level_q;
  assign fits = (32'(req_n) <= 32'(free));
  assign pop  = (level_q != '0) && tx_ready;

  // Command decode: what the triggered function asks for this cycle.
  always_comb begin
    logic stop;
    set_halt   = 1'b0;
    do_fail    = 1'b0;
    set_unsup  = 1'b0;
    want_print = 1'b0;
    req_n      = 4'd0;
    bytes      = '0;
    stop       = 1'b0;
    if (exec) begin
      case (args_q[0])
        DBG_EXIT:      set_halt = 1'b1;
        DBG_ASSERT_EQ: do_fail  = (args_q[1] != args_q[2]);
        DBG_ASSERT_NE: do_fail  = (args_q[1] == args_q[2]);
        DBG_PRINT: begin
          want_print = 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (!stop && (args_q[1][8*i +: 8] != 8'h00)) begin
              bytes[i] = args_q[1][8*i +: 8];
              req_n    = req_n + 4'd1;
            end else begin
              stop = 1'b1;
            end
          end
        end
`ifdef DBG_MAILBOX_HEX_EN
        DBG_PRINT_HEX: begin
          want_print = 1'b1;
          req_n      = 4'd8;
          for (int i = 0; i < 8; i++) bytes[i] = hex_ascii(args_q[1][28-4*i +: 4]);
        end
`else
        DBG_PRINT_HEX: set_unsup = 1'b1;
`endif
        DBG_CHECK_REGS, DBG_DUMP: ;
        default:       set_unsup = 1'b1;
      endcase
    end
  end

  // Argument store, trigger, sticky status and FIFO bookkeeping.
  always_comb begin
    args_d        = args_q;
    if (we) args_d[addr] = wdata;
    trigger_d     = we && (addr == 3'd0);
    halted_d      = halted_q | set_halt;
    assert_fail_d = assert_fail_q | do_fail;
    fail_cnt_d    = (do_fail && (fail_cnt_q != 8'hFF)) ? fail_cnt_q + 8'd1 : fail_cnt_q;
    overflow_d    = overflow_q | (want_print && !fits);
    unsupported_d = unsupported_q | set_unsup;
    // Atomic push: all requested bytes or none.
    push_n        = (want_print && fits) ? req_n : 4'd0;
    mem_d         = mem_q;
    for (int i = 0; i < 8; i++)
      if (4'(i) < push_n) mem_d[wptr_q + PW'(i)] = bytes[i];
    wptr_d        = wptr_q + PW'(push_n);
    rptr_d        = rptr_q + PW'(pop);
    level_d       = level_q + LW'(push_n) - LW'(pop);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      args_q        <= '0;
      trigger_q     <= 1'b0;
      halted_q      <= 1'b0;
      assert_fail_q <= 1'b0;
      overflow_q    <= 1'b0;
      unsupported_q <= 1'b0;
      fail_cnt_q    <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      level_q       <= '0;
    end else begin
      args_q        <= args_d;
      trigger_q     <= trigger_d;
      halted_q      <= halted_d;
      assert_fail_q <= assert_fail_d;
      overflow_q    <= overflow_d;
      unsupported_q <= unsupported_d;
      fail_cnt_q    <= fail_cnt_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      level_q       <= level_d;
    end
  end

  // FIFO storage; contents are don't-care while the level is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Status word and read mux.
  always_comb begin
    status                             = '0;
    status[ST_BUSY]                    = (level_q != '0) || !tx_idle;
    status[ST_HALTED]                  = halted_q;
    status[ST_ASSERT_FAIL]             = assert_fail_q;
    status[ST_OVERFLOW]                = overflow_q;
    status[ST_UNSUPPORTED]             = unsupported_q;
    status[ST_FAIL_LSB +: 8]           = fail_cnt_q;
    status[ST_LEVEL_LSB +: 8]          = 8'(level_q);
    rdata = (addr == 3'd0) ? status : args_q[addr];
  end

  assign halted      = halted_q;
  assign assert_fail = assert_fail_q;

  uart_tx_8n1 #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .reset (reset),
    .data  (mem_q[rptr_q]),
    .valid (level_q != '0),
    .ready (tx_ready),
    .idle  (tx_idle),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_dbg_mailbox_tx.sv
// Bench for dbg_mailbox_tx (CLK_DIV=4, FIFO_DEPTH=8). A serial monitor
// decodes frames and compares them against the expected-byte queue.
module tb_dbg_mailbox_tx;
  import dbg_mailbox_pkg::*;

  localparam int CD = 4;
  localparam int FD = 8;

  logic        clk = 1'b0, reset = 1'b1, we = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0, rdata;
  logic        uart_tx, halted, assert_fail;

  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] sb[$];
  int frame_starts[$];

  dbg_mailbox_tx #(.CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .uart_tx(uart_tx), .halted(halted), .assert_fail(assert_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Serial monitor: samples mid-bit on negedges, aborts on reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && uart_tx === 1'b0) begin
        logic [7:0] b;
        logic ok, aborted;
        int start;
        start = cyc; ok = 1'b1; aborted = 1'b0; b = '0;
        for (int k = 1; k < 10*CD; k++) begin
          @(negedge clk);
          if (reset) begin aborted = 1'b1; break; end
          if (k == CD/2 && uart_tx !== 1'b0) ok = 1'b0;
          for (int i = 0; i < 8; i++)
            if (k == CD*(i+1) + CD/2) b[i] = uart_tx;
          if (k == 9*CD + CD/2 && uart_tx !== 1'b1) ok = 1'b0;
        end
        if (!aborted) begin
          frame_starts.push_back(start);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL frame unexpected: got byte %02h, expected none", b);
          end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (b !== e || !ok) begin
              errors++;
              $display("FAIL frame: got byte %02h framing_ok=%0d, expected %02h framing_ok=1", b, ok, e);
            end
          end
        end
      end
    end
  end

  // Call at a negedge; leaves the bench at the negedge after capture.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; addr = 3'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1; we = 1'b0; addr = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference byte extraction for function 3.
  task automatic expect_print(input logic [31:0] v);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = v[8*i +: 8];
      if (b == 8'h00) break;
      sb.push_back(b);
    end
  endtask

  // Wait for busy to clear, then require every expected frame consumed.
  task automatic wait_idle(input int budget, input string name, output int n, output int peak);
    n = 0; peak = 0;
    @(negedge clk);
    while (rdata[ST_BUSY] === 1'b1 && n < budget) begin
      if (int'(rdata[23:16]) > peak) peak = int'(rdata[23:16]);
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s idle timeout: busy still 1 after %0d cycles", name, n);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s frames missing: %0d expected bytes not seen, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (uart_tx !== 1'b1 || halted !== 1'b0 || assert_fail !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: tx=%b halted=%b af=%b, expected 1 0 0", uart_tx, halted, assert_fail);
    end
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a); #1;
      checks++;
      if (rdata !== 32'd0) begin
        errors++;
        $display("FAIL reset rdata@%0d: got %08h, expected 00000000", a, rdata);
      end
    end
    addr = 3'd0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n, pk;
    frame_starts.delete();
    wr(3'd1, 32'h41);
    wr(3'd0, DBG_PRINT);
    expect_print(32'h41);
    wait_idle(200, "single", n, pk);
    checks++;
    if (n !== 10*CD + 1) begin
      errors++;
      $display("FAIL single busy length: got %0d cycles, expected %0d", n, 10*CD+1);
    end
    checks++;
    if (frame_starts.size() != 1) begin
      errors++;
      $display("FAIL single frame count: got %0d, expected 1", frame_starts.size());
    end
  endtask

  task automatic test_back_to_back();
    int n, pk;
    frame_starts.delete();
    wr(3'd1, 32'h0043_4241);
    wr(3'd0, DBG_PRINT);
    expect_print(32'h0043_4241);
    wait_idle(400, "b2b", n, pk);
    checks++;
    if (pk !== 3) begin
      errors++;
      $display("FAIL b2b level peak: got %0d, expected 3", pk);
    end
    checks++;
    if (frame_starts.size() != 3) begin
      errors++;
      $display("FAIL b2b frame count: got %0d, expected 3", frame_starts.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (frame_starts[i] - frame_starts[i-1] != 10*CD) begin
          errors++;
          $display("FAIL b2b gap %0d: got %0d cycles, expected %0d", i, frame_starts[i]-frame_starts[i-1], 10*CD);
        end
      end
    end
    // Zero first byte prints nothing.
    wr(3'd1, 32'h0041_0000);
    wr(3'd0, DBG_PRINT);
    @(negedge clk);
    checks++;
    if (rdata[ST_BUSY] !== 1'b0 || rdata[ST_OVERFLOW] !== 1'b0) begin
      errors++;
      $display("FAIL empty print: busy=%b ovf=%b, expected 0 0", rdata[ST_BUSY], rdata[ST_OVERFLOW]);
    end
  endtask

  task automatic test_asserts();
    do_reset();
    wr(3'd1, 32'd5); wr(3'd2, 32'd6); wr(3'd0, DBG_ASSERT_EQ);
    @(negedge clk);
    checks++;
    if (assert_fail !== 1'b1 || rdata[15:8] !== 8'd1 || rdata[ST_ASSERT_FAIL] !== 1'b1) begin
      errors++;
      $display("FAIL assert_eq: af=%b cnt=%0d, expected 1 1", assert_fail, rdata[15:8]);
    end
    wr(3'd1, 32'd7); wr(3'd2, 32'd7); wr(3'd0, DBG_ASSERT_NE);
    @(negedge clk);
    checks++;
    if (rdata[15:8] !== 8'd2) begin
      errors++;
      $display("FAIL assert_ne: cnt=%0d, expected 2", rdata[15:8]);
    end
    wr(3'd0, DBG_ASSERT_EQ);
    @(negedge clk);
    checks++;
    if (rdata[15:8] !== 8'd2) begin
      errors++;
      $display("FAIL assert_eq pass: cnt=%0d, expected 2", rdata[15:8]);
    end
    for (int i = 0; i < 300; i++) wr(3'd0, DBG_ASSERT_NE);
    @(negedge clk);
    checks++;
    if (rdata[15:8] !== 8'hFF) begin
      errors++;
      $display("FAIL fail_count saturate: got %02h, expected ff", rdata[15:8]);
    end
  endtask

  task automatic test_overflow();
    int n, pk;
    do_reset();
    wr(3'd1, 32'h4443_4241);
    wr(3'd0, DBG_PRINT); expect_print(32'h4443_4241);
    wr(3'd0, DBG_PRINT); expect_print(32'h4443_4241);
    checks++;
    if (rdata[ST_OVERFLOW] !== 1'b0) begin
      errors++;
      $display("FAIL overflow early: got %b, expected 0", rdata[ST_OVERFLOW]);
    end
    wr(3'd0, DBG_PRINT);
    @(negedge clk);
    checks++;
    if (rdata[ST_OVERFLOW] !== 1'b1 || rdata[23:16] !== 8'd7) begin
      errors++;
      $display("FAIL overflow: ovf=%b level=%0d, expected 1 7", rdata[ST_OVERFLOW], rdata[23:16]);
    end
    wait_idle(600, "overflow", n, pk);
  endtask

  task automatic test_unsupported();
    int n, pk;
    do_reset();
    wr(3'd0, DBG_CHECK_REGS);
    wr(3'd0, DBG_DUMP);
    @(negedge clk);
    checks++;
    if (rdata[ST_UNSUPPORTED] !== 1'b0) begin
      errors++;
      $display("FAIL no-op codes: unsupported=%b, expected 0", rdata[ST_UNSUPPORTED]);
    end
    wr(3'd0, 32'h1234);
    @(negedge clk);
    checks++;
    if (rdata[ST_UNSUPPORTED] !== 1'b1 || rdata[ST_BUSY] !== 1'b0) begin
      errors++;
      $display("FAIL unsupported 1234: unsup=%b busy=%b, expected 1 0", rdata[ST_UNSUPPORTED], rdata[ST_BUSY]);
    end
    do_reset();
    wr(3'd1, 32'hDEAD_BEEF);
    wr(3'd0, DBG_PRINT_HEX);
`ifdef DBG_MAILBOX_HEX_EN
    begin
      string s;
      s = "DEADBEEF";
      for (int i = 0; i < 8; i++) sb.push_back(s[i]);
    end
    wait_idle(600, "hex", n, pk);
    checks++;
    if (rdata[ST_UNSUPPORTED] !== 1'b0) begin
      errors++;
      $display("FAIL hex: unsupported=%b, expected 0", rdata[ST_UNSUPPORTED]);
    end
`else
    wait_idle(60, "hex", n, pk);
    checks++;
    if (rdata[ST_UNSUPPORTED] !== 1'b1) begin
      errors++;
      $display("FAIL hex disabled: unsupported=%b, expected 1", rdata[ST_UNSUPPORTED]);
    end
`endif
  endtask

  task automatic test_halt_and_reset();
    do_reset();
    wr(3'd0, DBG_EXIT);
    wr(3'd1, 32'h5A);
    wr(3'd0, DBG_PRINT);
    repeat (3) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || rdata[ST_HALTED] !== 1'b1 || rdata[ST_BUSY] !== 1'b0) begin
      errors++;
      $display("FAIL halt: halted=%b st=%b busy=%b, expected 1 1 0", halted, rdata[ST_HALTED], rdata[ST_BUSY]);
    end
    addr = 3'd1; #1;
    checks++;
    if (rdata !== 32'h5A) begin
      errors++;
      $display("FAIL halt arg write: got %08h, expected 0000005a", rdata);
    end
    addr = 3'd0;
    // Mid-frame reset with sticky bits set and bytes still queued.
    do_reset();
    wr(3'd1, 32'd1); wr(3'd2, 32'd2); wr(3'd0, DBG_ASSERT_EQ);
    wr(3'd1, 32'h4443_4241); wr(3'd0, DBG_PRINT);
    expect_print(32'h4443_4241);
    repeat (15) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0 && rdata[ST_BUSY] !== 1'b1) begin
      errors++;
      $display("FAIL mid-frame setup: busy=%b, expected 1", rdata[ST_BUSY]);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1 || rdata !== 32'd0 || assert_fail !== 1'b0) begin
      errors++;
      $display("FAIL mid-frame reset: tx=%b status=%08h af=%b, expected 1 00000000 0", uart_tx, rdata, assert_fail);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    repeat (60) @(negedge clk);
    checks++;
    if (rdata !== 32'd0 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL post-reset drain: status=%08h tx=%b, expected 00000000 1", rdata, uart_tx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_asserts();
    test_overflow();
    test_unsupported();
    test_halt_and_reset();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
